// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake, operands and held result of the
// bit-serial adder. The optional signed-overflow flag (ovf) is present only
// when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_ADDER_OVF_EN
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, carry_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, carry_out, ovf
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, carry_out
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. Adds a + b + c_in LSB-first, one bit per
// clock, through a single full-adder cell and a carry flip-flop. A result is
// published WIDTH edges after start is accepted, followed by a one-cycle done.
// Optional feature: define SERIAL_ADDER_OVF_EN to add a two's-complement
// overflow flag (bus.ovf), captured and held alongside sum.
// WIDTH must match the WIDTH of the connected serial_adder_if.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] shift_a_reg;
  logic [WIDTH-1:0] shift_b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_out_reg;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg;
`endif

  logic             bit_s;
  logic             carry_next;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;

  // Full-adder cell on the current LSBs, plus the accumulator with the new
  // sum bit entering at the MSB end (after WIDTH shifts bit 0 lands at bit 0).
  always_comb begin
    bit_s      = shift_a_reg[0] ^ shift_b_reg[0] ^ carry_reg;
    carry_next = (shift_a_reg[0] & shift_b_reg[0]) |
                 (shift_a_reg[0] & carry_reg) |
                 (shift_b_reg[0] & carry_reg);
    acc_next   = (acc_reg >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
    last_bit   = (cnt_reg == CW'(WIDTH - 1));
  end

  // Handshake FSM and datapath; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_a_reg   <= '0;
      shift_b_reg   <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        // DONE accepts a new start exactly like IDLE, giving back-to-back ops.
        IDLE, DONE: begin
          if (bus.start) begin
            shift_a_reg <= bus.a;
            shift_b_reg <= bus.b;
            carry_reg   <= bus.c_in;
            cnt_reg     <= '0;
            state_reg   <= RUN;
          end else begin
            state_reg   <= IDLE;
          end
        end
        RUN: begin
          shift_a_reg <= shift_a_reg >> 1;
          shift_b_reg <= shift_b_reg >> 1;
          carry_reg   <= carry_next;
          acc_reg     <= acc_next;
          cnt_reg     <= cnt_reg + CW'(1);
          if (last_bit) begin
            sum_reg       <= acc_next;
            carry_out_reg <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_reg is the carry into the MSB, carry_next the carry out.
            ovf_reg       <= carry_reg ^ carry_next;
`endif
            state_reg     <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_reg == RUN);
  assign bus.done      = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.carry_out = carry_out_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 (latency,
// ignored start, mid-operation reset, back-to-back) and an exhaustive sweep at
// WIDTH=4. Overflow checks are included when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit addition from IDLE: busy for 8 cycles, done on the 9th, then idle.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cin,
                     input logic [8:0] exp, input string tag);
    int busy_cycles;
    bus8.a = av;
    bus8.b = bv;
    bus8.c_in = cin;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    busy_cycles = int'(bus8.busy);
    repeat (7) begin
      tick();
      busy_cycles += int'(bus8.busy);
    end
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
    tick();
    check({tag, "_done"}, 32'({bus8.done, bus8.busy}), 32'b10);
    check({tag, "_result"}, 32'({bus8.carry_out, bus8.sum}), 32'(exp));
    tick();
    check({tag, "_done_drop"}, 32'(bus8.done), 32'd0);
  endtask

  initial begin
    int dones;
    int k;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_busy_done", 32'({bus8.busy, bus8.done}), 32'd0);
    check("rst_result", 32'({bus8.carry_out, bus8.sum}), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(bus8.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed 8-bit vectors, expected {carry_out, sum} worked out by hand.
    op8(8'hFF, 8'h01, 1'b0, 9'h100, "ff_01");
    op8(8'h00, 8'h00, 1'b1, 9'h001, "00_00_c");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ff_ff_c");
    op8(8'hA5, 8'h5A, 1'b0, 9'h0FF, "a5_5a");
    op8(8'h80, 8'h80, 1'b0, 9'h100, "80_80");

    // A start pulse during RUN must be ignored.
    bus8.a = 8'h03; bus8.b = 8'h04; bus8.c_in = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 3) begin
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;
      end
      if (e == 4) bus8.start = 1'b0;
      tick();
      dones += int'(bus8.done);
      if (e == 8) begin
        check("ign_done", 32'(bus8.done), 32'd1);
        check("ign_result", 32'({bus8.carry_out, bus8.sum}), 32'h007);
      end
    end
    check("ign_single_done", 32'(dones), 32'd1);

    // Reset in RUN cycle 4 clears everything immediately.
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.c_in = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (3) tick();
    check("mid_busy_before", 32'(bus8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", 32'({bus8.busy, bus8.done}), 32'd0);
    check("mid_rst_result", 32'({bus8.carry_out, bus8.sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_no_done", 32'(bus8.done), 32'd0);
    op8(8'h10, 8'h20, 1'b1, 9'h031, "after_rst");

    // Back-to-back: start held into the DONE cycle launches the next run.
    bus8.a = 8'h01; bus8.b = 8'h02; bus8.c_in = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (7) tick();
    bus8.start = 1'b1; bus8.a = 8'h0F; bus8.b = 8'h01;
    tick();
    check("b2b_first_done", 32'(bus8.done), 32'd1);
    check("b2b_first_sum", 32'(bus8.sum), 32'h03);
    tick();
    bus8.start = 1'b0;
    check("b2b_busy_again", 32'({bus8.busy, bus8.done}), 32'b10);
    check("b2b_hold_early", 32'(bus8.sum), 32'h03);
    repeat (7) tick();
    check("b2b_hold_late", 32'({bus8.busy, bus8.sum}), 32'h103);
    tick();
    check("b2b_second_done", 32'(bus8.done), 32'd1);
    check("b2b_second_result", 32'({bus8.carry_out, bus8.sum}), 32'h010);
    tick();

`ifdef SERIAL_ADDER_OVF_EN
    op8(8'h7F, 8'h01, 1'b0, 9'h080, "ovf_7f_01");
    check("ovf_7f_01_flag", 32'(bus8.ovf), 32'd1);
    op8(8'h80, 8'hFF, 1'b0, 9'h17F, "ovf_80_ff");
    check("ovf_80_ff_flag", 32'(bus8.ovf), 32'd1);
    op8(8'hFF, 8'h01, 1'b0, 9'h100, "ovf_ff_01");
    check("ovf_ff_01_flag", 32'(bus8.ovf), 32'd0);
`endif

    // Exhaustive WIDTH=4 sweep with a bounded wait for each done.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          bus4.a = 4'(ai); bus4.b = 4'(bi); bus4.c_in = 1'(ci); bus4.start = 1'b1;
          tick();
          bus4.start = 1'b0;
          k = 0;
          while (!bus4.done && k < 10) begin
            tick();
            k++;
          end
          check("w4_latency", 32'(k), 32'd4);
          check("w4_result", 32'({bus4.carry_out, bus4.sum}), 32'(ai + bi + ci));
          tick();
          check("w4_done_pulse", 32'(bus4.done), 32'd0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder: adds two WIDTH-bit operands plus carry-in LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Sits upstream of result consumers as the area-cheap alternative to the ripple adder. It drives the 1-bit full-adder cell each cycle with (a_i, b_i, carry) and collects its sum/carry outputs.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on an accepted start
- b  input  WIDTH  operand B, captured on an accepted start
- c_in  input  1  carry-in, captured on an accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/carry_out are updated
- sum  output  WIDTH  result of the last completed addition, held
- carry_out  output  1  final carry of the last completed addition, held

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Forces state IDLE, busy=0, done=0, sum=0, carry_out=0.
  - Clears internal shift registers, the carry FF and the bit counter.
  - A reset mid-operation aborts it. No done is produced and no partial result is visible.
- State IDLE (busy=0, done=0):
  - When start=1 at an edge: load shift_a<=a, shift_b<=b, carry<=c_in, cnt<=0, then go to RUN.
  - When start=0: stay in IDLE.
- State RUN (busy=1), at each edge:
  - s = shift_a[0]^shift_b[0]^carry.
  - carry <= majority(shift_a[0], shift_b[0], carry).
  - shift_a and shift_b shift right by 1.
  - Internal acc shifts right with s inserted at bit WIDTH-1.
  - cnt increments.
  - start is ignored; a, b and c_in are don't-care.
- Completion:
  - On the edge where cnt==WIDTH-1, the last bit is processed.
  - At that edge, sum <= the completed acc value, including this last bit, and carry_out <= the final carry.
  - The block then moves to DONE.
- State DONE (busy=0, done=1, lasts exactly one cycle):
  - start=1 is accepted exactly as in IDLE and goes to RUN.
  - Otherwise the block goes to IDLE.
- Latency:
  - With start accepted at edge E0, busy is high for E0+ through the cycle ending at edge E_WIDTH.
  - done is high in the cycle after E_WIDTH.
  - Result is valid WIDTH edges after acceptance.
  - Throughput is one addition per WIDTH+1 cycles when back-to-back (start held in DONE).
- Output holding:
  - sum and carry_out change only at completion.
  - They keep their previous values during RUN and IDLE.
- Arithmetic: {carry_out, sum} == a + b + c_in, modulo 2^(WIDTH+1). The result is exact and never truncated.
- Counter width is $clog2(WIDTH+1). WIDTH=1 completes in one RUN cycle.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (output, 1 bit) for two's-complement signed overflow.
  - ovf = carry into the MSB XOR carry out of the MSB, captured at completion together with sum.
  - ovf resets to 0 and is held like sum.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, c_in=0 -> done exactly 8 edges after acceptance; sum=8'h00, carry_out=1. busy is high for 8 cycles, then done is high for 1 cycle with busy=0.
- WIDTH=4, exhaustive 16x16x2 combinations -> {carry_out, sum} == a+b+c_in for all 512 cases. done pulses once per operation.
- start a=8'h03, b=8'h04, c_in=0; at cycle 3 of RUN pulse start with a=8'hAA, b=8'h55 -> second request ignored; result sum=8'h07, carry_out=0, single done.
- Reset mid-operation: start a=8'h80, b=8'h80, drop rst_n at RUN cycle 4 -> busy, done, sum and carry_out are 0 immediately. After release, a=8'h10, b=8'h20, c_in=1 gives sum=8'h31.
- Back-to-back: start held high through the DONE cycle with new a=8'h0F, b=8'h01 -> busy rises the next cycle. First result is held during the second run, then updates to 8'h10.
- With SERIAL_ADDER_OVF_EN defined:
  - a=8'h7F, b=8'h01 -> ovf=1, sum=8'h80.
  - a=8'h80, b=8'hFF -> ovf=1, carry_out=1.
  - a=8'hFF, b=8'h01 -> ovf=0, carry_out=1.
